// File: rtl/s1269_host_seq_if.sv
// Bundles the s1269 host request/response handshakes and the datapath command bus.
// The master modport is the sequencer view; the slave modport is the host plus datapath side.
interface s1269_host_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_ins;
  logic [7:0] req_dr;
  logic [7:0] req_mq;
  logic [7:0] req_acc;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_acc;
  logic [7:0] rsp_mq;
  logic       rsp_err;
  logic [2:0] INS;
  logic       LDDR;
  logic       LDMQ;
  logic       LDAcc;
  logic       STDR;
  logic       STMQ;
  logic       STAcc;
  logic [7:0] inBUS;
  logic       TESTMODE;
  logic [7:0] outBUS;
  logic       RDY;

  modport master (
    input  req_valid, req_ins, req_dr, req_mq, req_acc, rsp_ready, outBUS, RDY,
    output req_ready, rsp_valid, rsp_acc, rsp_mq, rsp_err,
    output INS, LDDR, LDMQ, LDAcc, STDR, STMQ, STAcc, inBUS, TESTMODE
  );

  modport slave (
    output req_valid, req_ins, req_dr, req_mq, req_acc, rsp_ready, outBUS, RDY,
    input  req_ready, rsp_valid, rsp_acc, rsp_mq, rsp_err,
    input  INS, LDDR, LDMQ, LDAcc, STDR, STMQ, STAcc, inBUS, TESTMODE
  );
endinterface

// File: rtl/s1269_host_seq.sv
// Sequencer that loads DR/MQ/Acc, issues INS, waits for RDY and reads Acc/MQ back.
// Optional RDY watchdog is compiled in with S1269_HOST_WATCHDOG_EN.
module s1269_host_seq #(
  parameter int unsigned WAIT_MAX = 64,
  parameter int unsigned SETTLE   = 1
) (
  input logic               clock,
  input logic               reset_n,
  s1269_host_seq_if.master  bus
);

  if (SETTLE < 1 || SETTLE > 7) begin : g_bad_settle
    $error("SETTLE out of range");
  end
  if (WAIT_MAX < 2 || WAIT_MAX > 255) begin : g_bad_wait_max
    $error("WAIT_MAX out of range");
  end

  typedef enum logic [3:0] {
    StIdle, StLdDr, StLdMq, StLdAcc, StExec, StWait, StStAcc, StStMq, StResp
  } state_e;

  localparam logic [2:0] SettleLast = 3'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [2:0] settle_q, settle_d;
  logic [2:0] ins_q, ins_d;
  logic [7:0] dr_q, dr_d, mq_q, mq_d, acc_q, acc_d;
  logic       req_ready_q, req_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_acc_q, rsp_acc_d, rsp_mq_q, rsp_mq_d;
  logic [2:0] ins_out_q, ins_out_d;
  logic       ld_dr_q, ld_dr_d, ld_mq_q, ld_mq_d, ld_acc_q, ld_acc_d;
  logic       st_mq_q, st_mq_d, st_acc_q, st_acc_d;
  logic [7:0] in_bus_q, in_bus_d;
`ifdef S1269_HOST_WATCHDOG_EN
  localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);
  logic [7:0] wait_q, wait_d;
  logic       rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    ins_d     = ins_q;
    dr_d      = dr_q;
    mq_d      = mq_q;
    acc_d     = acc_q;
    rsp_acc_d = rsp_acc_q;
    rsp_mq_d  = rsp_mq_q;
`ifdef S1269_HOST_WATCHDOG_EN
    wait_d    = wait_q;
    rsp_err_d = rsp_err_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.req_valid && req_ready_q) begin
          state_d = StLdDr;
          ins_d   = bus.req_ins;
          dr_d    = bus.req_dr;
          mq_d    = bus.req_mq;
          acc_d   = bus.req_acc;
`ifdef S1269_HOST_WATCHDOG_EN
          rsp_err_d = 1'b0;
`endif
        end
      end
      StLdDr:  state_d = StLdMq;
      StLdMq:  state_d = StLdAcc;
      StLdAcc: begin
        state_d  = StExec;
        settle_d = 3'd0;
      end
      StExec: begin
        // RDY is deliberately not looked at until WAIT
        if (settle_q == SettleLast) begin
          state_d = StWait;
`ifdef S1269_HOST_WATCHDOG_EN
          wait_d  = 8'd0;
`endif
        end else begin
          settle_d = settle_q + 3'd1;
        end
      end
      StWait: begin
        if (bus.RDY) begin
          state_d = StStAcc;
        end
`ifdef S1269_HOST_WATCHDOG_EN
        else if (wait_q == WaitLast) begin
          state_d   = StResp;
          rsp_acc_d = 8'hFF;
          rsp_mq_d  = 8'hFF;
          rsp_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
`endif
      end
      StStAcc: begin
        rsp_acc_d = bus.outBUS;
        state_d   = StStMq;
      end
      StStMq: begin
        rsp_mq_d = bus.outBUS;
        state_d  = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so every port comes straight from a flop
    req_ready_d = (state_d == StIdle);
    rsp_valid_d = (state_d == StResp);
    ld_dr_d     = (state_d == StLdDr);
    ld_mq_d     = (state_d == StLdMq);
    ld_acc_d    = (state_d == StLdAcc);
    st_acc_d    = (state_d == StStAcc);
    st_mq_d     = (state_d == StStMq);
    ins_out_d   = (state_d inside {StExec, StWait, StStAcc, StStMq, StResp}) ? ins_d : 3'd0;
    case (state_d)
      StLdDr:  in_bus_d = dr_d;
      StLdMq:  in_bus_d = mq_d;
      StLdAcc: in_bus_d = acc_d;
      default: in_bus_d = 8'h00;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      settle_q    <= 3'd0;
      ins_q       <= 3'd0;
      dr_q        <= 8'h00;
      mq_q        <= 8'h00;
      acc_q       <= 8'h00;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_acc_q   <= 8'h00;
      rsp_mq_q    <= 8'h00;
      ins_out_q   <= 3'd0;
      ld_dr_q     <= 1'b0;
      ld_mq_q     <= 1'b0;
      ld_acc_q    <= 1'b0;
      st_mq_q     <= 1'b0;
      st_acc_q    <= 1'b0;
      in_bus_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      ins_q       <= ins_d;
      dr_q        <= dr_d;
      mq_q        <= mq_d;
      acc_q       <= acc_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_acc_q   <= rsp_acc_d;
      rsp_mq_q    <= rsp_mq_d;
      ins_out_q   <= ins_out_d;
      ld_dr_q     <= ld_dr_d;
      ld_mq_q     <= ld_mq_d;
      ld_acc_q    <= ld_acc_d;
      st_mq_q     <= st_mq_d;
      st_acc_q    <= st_acc_d;
      in_bus_q    <= in_bus_d;
    end
  end

`ifdef S1269_HOST_WATCHDOG_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_q    <= 8'd0;
      rsp_err_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_acc   = rsp_acc_q;
  assign bus.rsp_mq    = rsp_mq_q;
  assign bus.INS       = ins_out_q;
  assign bus.LDDR      = ld_dr_q;
  assign bus.LDMQ      = ld_mq_q;
  assign bus.LDAcc     = ld_acc_q;
  assign bus.STDR      = 1'b0;
  assign bus.STMQ      = st_mq_q;
  assign bus.STAcc     = st_acc_q;
  assign bus.inBUS     = in_bus_q;
  assign bus.TESTMODE  = 1'b0;

endmodule

// File: tb/tb_s1269_host_seq.sv
// Directed bench for s1269_host_seq with a small datapath model (outBUS and RDY).
module tb_s1269_host_seq;
  localparam int unsigned SETTLE   = 3;
  localparam int unsigned WAIT_MAX = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_asrt = 0;
  int   n_fail = 0;

  s1269_host_seq_if bus ();

  s1269_host_seq #(.WAIT_MAX(WAIT_MAX), .SETTLE(SETTLE)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Datapath model: RDY mode 0 = stuck low, 1 = always high, 2 = high from 5 cycles after LDAcc
  int         since = 0;
  int         rdy_mode = 0;
  logic [7:0] dp_acc = 8'h00;
  logic [7:0] dp_mq = 8'h00;
  logic [5:0] strb;

  always @(posedge clock) begin
    if (bus.LDAcc) since <= 1;
    else if (since > 0 && since < 1000) since <= since + 1;
  end

  always_comb begin
    bus.RDY    = (rdy_mode == 1) || (rdy_mode == 2 && since >= 5);
    bus.outBUS = bus.STAcc ? dp_acc : (bus.STMQ ? dp_mq : 8'h00);
  end

  assign strb = {bus.LDDR, bus.LDMQ, bus.LDAcc, bus.STDR, bus.STMQ, bus.STAcc};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] i, input logic [7:0] d, input logic [7:0] m,
                      input logic [7:0] a);
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_ins   = i;
    bus.req_dr    = d;
    bus.req_mq    = m;
    bus.req_acc   = a;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int         cnt;
    logic       seen;
    logic [31:0] rv;
    logic [31:0] rr;
    bus.req_valid = 1'b0;
    bus.req_ins   = 3'd0;
    bus.req_dr    = 8'h00;
    bus.req_mq    = 8'h00;
    bus.req_acc   = 8'h00;
    bus.rsp_ready = 1'b0;

    repeat (2) @(negedge clock);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_strobes", 32'(strb), 32'd0);
    chk("rst_inbus", 32'(bus.inBUS), 32'h00);
    chk("rst_ins", 32'(bus.INS), 32'd0);
    chk("rst_rsp_data", {16'd0, bus.rsp_acc, bus.rsp_mq}, 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_testmode", 32'(bus.TESTMODE), 32'd0);
    reset_n = 1'b1;

    // Reset asserted in the middle of LD_MQ
    send(3'b011, 8'hAA, 8'hBB, 8'hCC);
    @(negedge clock);
    @(negedge clock);
    chk("midrst_ldmq", 32'(strb), 32'b010000);
    chk("midrst_ldmq_bus", 32'(bus.inBUS), 32'hBB);
    reset_n = 1'b0;
    @(negedge clock);
    chk("midrst_strobes", 32'(strb), 32'd0);
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_inbus", 32'(bus.inBUS), 32'h00);
    reset_n = 1'b1;

    // Main transaction: RDY rises on the second WAIT cycle
    rdy_mode = 2;
    dp_acc   = 8'h12;
    dp_mq    = 8'h34;
    send(3'b101, 8'h3C, 8'h05, 8'h00);
    @(negedge clock);
    chk("ld_dr", {24'(strb), bus.inBUS}, {24'b100000, 8'h3C});
    chk("ld_dr_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clock);
    chk("ld_mq", {24'(strb), bus.inBUS}, {24'b010000, 8'h05});
    @(negedge clock);
    chk("ld_acc", {24'(strb), bus.inBUS}, {24'b001000, 8'h00});
    for (int k = 4; k <= 8; k++) begin
      @(negedge clock);
      chk("exec_wait_ins", {21'd0, bus.INS, strb, bus.inBUS}, {21'd0, 3'b101, 6'd0, 8'h00});
    end
    @(negedge clock);
    chk("st_acc", 32'(strb), 32'b000001);
    @(negedge clock);
    chk("st_mq", 32'(strb), 32'b000010);
    chk("st_mq_no_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clock);

    // Hold RESP for 5 cycles; a request pulse must be ignored
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        bus.req_valid = 1'b1;
        bus.req_ins   = 3'b111;
        bus.req_dr    = 8'h99;
      end
      if (k == 2) bus.req_valid = 1'b0;
      chk("resp_hold", {7'd0, bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.STAcc, bus.STMQ,
                        bus.rsp_acc, bus.rsp_mq}, {7'd0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h12, 8'h34});
      @(negedge clock);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    chk("resp_done", {bus.rsp_valid, bus.req_ready}, 2'b01);
    @(negedge clock);
    chk("pulse_ignored", {23'd0, bus.req_ready, strb, bus.INS}, {23'd0, 1'b1, 6'd0, 3'd0});

    // RDY high during EXEC: latency 3 + SETTLE(3) + 1 + 2 + 1
    rdy_mode = 1;
    dp_acc   = 8'h56;
    dp_mq    = 8'h78;
    send(3'b010, 8'h11, 8'h22, 8'h33);
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while (!bus.rsp_valid && cnt < 40);
    chk("settle_latency", 32'(cnt), 32'd10);
    chk("settle_rsp", {16'd0, bus.rsp_acc, bus.rsp_mq}, 32'h5678);
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    chk("settle_clear", 32'(bus.rsp_valid), 32'd0);

    // Back-to-back requests with req_valid and rsp_ready always high
    dp_acc = 8'h9A;
    dp_mq  = 8'hBC;
    rv = '0;
    rr = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_ins   = 3'b001;
    @(posedge clock);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      rv[c] = bus.rsp_valid;
      rr[c] = bus.req_ready;
    end
    bus.req_valid = 1'b0;
    chk("b2b_rsp_valid", rv, (32'd1 << 10) | (32'd1 << 21));
    chk("b2b_req_ready", rr, (32'd1 << 11) | (32'd1 << 22));
    repeat (5) @(negedge clock);
    chk("b2b_idle", {bus.req_ready, bus.rsp_valid}, 2'b10);
    bus.rsp_ready = 1'b0;

    // RDY stuck low
    rdy_mode = 0;
    send(3'b110, 8'h01, 8'h02, 8'h03);
`ifdef S1269_HOST_WATCHDOG_EN
    seen = 1'b0;
    cnt  = 0;
    do begin
      @(negedge clock);
      cnt++;
      seen = seen | bus.STAcc | bus.STMQ | bus.STDR;
    end while (!bus.rsp_valid && cnt < 40);
    chk("wd_latency", 32'(cnt), 32'd11);
    chk("wd_no_store", 32'(seen), 32'd0);
    chk("wd_rsp", {15'd0, bus.rsp_err, bus.rsp_acc, bus.rsp_mq}, {15'd0, 1'b1, 8'hFF, 8'hFF});
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    chk("wd_clear", {bus.rsp_valid, bus.req_ready}, 2'b01);
`else
    seen = 1'b0;
    repeat (30) begin
      @(negedge clock);
      seen = seen | bus.rsp_valid | bus.rsp_err;
    end
    chk("stuck_no_rsp", 32'(seen), 32'd0);
    chk("stuck_ins_held", {bus.INS, strb}, {3'b110, 6'd0});
    dp_acc   = 8'h4D;
    dp_mq    = 8'hE2;
    rdy_mode = 1;
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while (!bus.rsp_valid && cnt < 40);
    chk("stuck_release_lat", 32'(cnt), 32'd3);
    chk("stuck_release_rsp", {15'd0, bus.rsp_err, bus.rsp_acc, bus.rsp_mq},
        {15'd0, 1'b0, 8'h4D, 8'hE2});
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
